// File: rtl/cmd_phys_layer.sv
// SD host CMD physical layer.
// Takes a 40-bit command from the CMD control block and appends CRC7 and the
// end bit. Shifts the 48-bit frame out MSB first on the CMD pad, then captures
// the card's 48- or 136-bit response with optional response-start timeout.
// Every pad and handshake output is registered, so outputs follow the state
// register by one clock.
module cmd_phys_layer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         strobe_in,
  input  logic [39:0]  cmd_to_send,
  input  logic [1:0]   response_type,
  input  logic         timeout_enable,
  input  logic         ack_in,
  output logic         strobe_out,
  output logic         ack_out,
  output logic [127:0] cmd_response,
  output logic         time_out,
  output logic         crc_error,
  input  logic         cmd_pin_in,
  output logic         cmd_pin_out,
  output logic         cmd_pin_oe
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RESP,
    S_RECEIVE,
    S_DONE,
    S_ACK
  } state_t;

  state_t         state_q;
  logic [47:0]    tx_q;
  logic [127:0]   rx_q;
  logic [7:0]     cnt_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [1:0]     resp_type_q;
  logic           to_en_q;
  logic           armed_q;
  logic           strobe_out_q;
  logic           ack_out_q;
  logic [127:0]   cmd_response_q;
  logic           time_out_q;
  logic           crc_error_q;
  logic           pin_out_q;
  logic           pin_oe_q;

  logic [47:0]    tx_frame_d;
  logic           rx_crc_bad_d;
  logic [7:0]     rx_last_d;

  // CRC7, polynomial x^7 + x^3 + 1, zero initial value, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) begin
        crc = crc ^ 7'h09;
      end
    end
    return crc;
  endfunction

  // Frame to transmit, CRC check of a short response, and the index of the
  // last response bit (start bit is index 0).
  always_comb begin
    tx_frame_d   = {cmd_to_send, crc7(cmd_to_send), 1'b1};
    rx_crc_bad_d = (crc7(rx_q[47:8]) != rx_q[7:1]);
    rx_last_d    = (resp_type_q == 2'b10) ? 8'd135 : 8'd47;
  end

  // Main transaction FSM with registered pad and handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      tx_q           <= '0;
      rx_q           <= '0;
      cnt_q          <= '0;
      to_cnt_q       <= '0;
      resp_type_q    <= '0;
      to_en_q        <= 1'b0;
      armed_q        <= 1'b1;
      strobe_out_q   <= 1'b0;
      ack_out_q      <= 1'b0;
      cmd_response_q <= '0;
      time_out_q     <= 1'b0;
      crc_error_q    <= 1'b0;
      pin_out_q      <= 1'b1;
      pin_oe_q       <= 1'b0;
    end else begin
      // A request is re-armed only once control has been seen idle, so a
      // strobe still held after the ack pulse cannot start a second command.
      if (!strobe_in) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          pin_oe_q     <= 1'b0;
          pin_out_q    <= 1'b1;
          strobe_out_q <= 1'b0;
          ack_out_q    <= 1'b0;
          cnt_q        <= '0;
          to_cnt_q     <= '0;
          if (strobe_in && armed_q) begin
            tx_q           <= tx_frame_d;
            resp_type_q    <= response_type;
            to_en_q        <= timeout_enable;
            rx_q           <= '0;
            cmd_response_q <= '0;
            time_out_q     <= 1'b0;
            crc_error_q    <= 1'b0;
            armed_q        <= 1'b0;
            state_q        <= S_SEND;
          end
        end

        S_SEND: begin
          pin_oe_q  <= 1'b1;
          pin_out_q <= tx_q[47];
          tx_q      <= {tx_q[46:0], 1'b1};
          if (cnt_q == 8'd47) begin
            cnt_q   <= '0;
            state_q <= (resp_type_q == 2'b00) ? S_DONE : S_WAIT_RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_WAIT_RESP: begin
          pin_oe_q  <= 1'b0;
          pin_out_q <= 1'b1;
          // The start bit takes priority over a timeout reached in the same cycle.
          if (!cmd_pin_in) begin
            rx_q    <= {rx_q[126:0], cmd_pin_in};
            cnt_q   <= 8'd1;
            state_q <= S_RECEIVE;
          end else if (to_en_q && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
            time_out_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end

        S_RECEIVE: begin
          pin_oe_q  <= 1'b0;
          pin_out_q <= 1'b1;
          rx_q      <= {rx_q[126:0], cmd_pin_in};
          if (cnt_q == rx_last_d) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_DONE: begin
          pin_oe_q  <= 1'b0;
          pin_out_q <= 1'b1;
          if (!strobe_out_q) begin
            // First DONE cycle: publish the result together with strobe_out.
            strobe_out_q <= 1'b1;
            if (!time_out_q) begin
              case (resp_type_q)
                2'b00: begin
                  cmd_response_q <= '0;
                  crc_error_q    <= 1'b0;
                end
                2'b10: begin
                  cmd_response_q <= rx_q;
                  crc_error_q    <= 1'b0;
                end
                default: begin
                  cmd_response_q <= {80'h0, rx_q[47:0]};
                  crc_error_q    <= rx_crc_bad_d;
                end
              endcase
            end
          end else if (ack_in) begin
            state_q <= S_ACK;
          end
        end

        S_ACK: begin
          pin_oe_q  <= 1'b0;
          pin_out_q <= 1'b1;
          if (!ack_out_q) begin
            strobe_out_q <= 1'b0;
            ack_out_q    <= 1'b1;
          end else begin
            ack_out_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign strobe_out   = strobe_out_q;
  assign ack_out      = ack_out_q;
  assign cmd_response = cmd_response_q;
  assign time_out     = time_out_q;
  assign crc_error    = crc_error_q;
  assign cmd_pin_out  = pin_out_q;
  assign cmd_pin_oe   = pin_oe_q;

endmodule

// File: tb/tb_cmd_phys_layer.sv
// Directed bench for cmd_phys_layer: frame serialization, short/long response
// capture, CRC error, timeout, handshake and asynchronous reset.
module tb_cmd_phys_layer;

  logic         clock;
  logic         reset;
  logic         strobe_in;
  logic [39:0]  cmd_to_send;
  logic [1:0]   response_type;
  logic         timeout_enable;
  logic         ack_in;
  logic         strobe_out;
  logic         ack_out;
  logic [127:0] cmd_response;
  logic         time_out;
  logic         crc_error;
  logic         cmd_pin_in;
  logic         cmd_pin_out;
  logic         cmd_pin_oe;

  int n_checks;
  int n_errors;

  cmd_phys_layer #(.TIMEOUT_CYCLES(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .strobe_in     (strobe_in),
    .cmd_to_send   (cmd_to_send),
    .response_type (response_type),
    .timeout_enable(timeout_enable),
    .ack_in        (ack_in),
    .strobe_out    (strobe_out),
    .ack_out       (ack_out),
    .cmd_response  (cmd_response),
    .time_out      (time_out),
    .crc_error     (crc_error),
    .cmd_pin_in    (cmd_pin_in),
    .cmd_pin_out   (cmd_pin_out),
    .cmd_pin_oe    (cmd_pin_oe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a command and capture the 48 bits seen on the pad. Returns just
  // after the edge that drives the last (end) bit.
  task automatic run_cmd(input logic [39:0] cmd, input logic [1:0] rt, input logic ten,
                         output logic [47:0] frame, output logic oe_ok);
    cmd_to_send    = cmd;
    response_type  = rt;
    timeout_enable = ten;
    strobe_in      = 1'b1;
    tick();
    oe_ok = (cmd_pin_oe == 1'b0);
    frame = '0;
    for (int i = 0; i < 48; i++) begin
      tick();
      frame = {frame[46:0], cmd_pin_out};
      if (cmd_pin_oe !== 1'b1) oe_ok = 1'b0;
    end
  endtask

  // Card drives a response: gap idle cycles, then nbits bits MSB first.
  task automatic card_resp(input logic [135:0] bits, input int nbits, input int gap);
    for (int i = 0; i < gap; i++) tick();
    for (int i = nbits - 1; i >= 0; i--) begin
      cmd_pin_in = bits[i];
      tick();
    end
    cmd_pin_in = 1'b1;
  endtask

  // Control consumes the result; optionally keeps strobe_in high afterwards.
  task automatic do_ack(input string tag, input logic hold);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    check_val({tag, "_strobe_at_a"}, strobe_out, 1'b1);
    check_val({tag, "_ack_at_a"}, ack_out, 1'b0);
    tick();
    check_val({tag, "_strobe_at_a1"}, strobe_out, 1'b0);
    check_val({tag, "_ack_at_a1"}, ack_out, 1'b1);
    if (!hold) strobe_in = 1'b0;
    tick();
    check_val({tag, "_ack_at_a2"}, ack_out, 1'b0);
  endtask

  logic [47:0]  frame;
  logic         oe_ok;
  logic         seen;
  logic [135:0] long_pat;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    strobe_in      = 1'b0;
    cmd_to_send    = '0;
    response_type  = 2'b00;
    timeout_enable = 1'b0;
    ack_in         = 1'b0;
    cmd_pin_in     = 1'b1;
    long_pat       = {8'h3F, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211};

    tick();
    tick();
    check_val("rst_strobe", strobe_out, 1'b0);
    check_val("rst_ack", ack_out, 1'b0);
    check_val("rst_oe", cmd_pin_oe, 1'b0);
    check_val("rst_pin", cmd_pin_out, 1'b1);
    check_val("rst_resp", cmd_response, 128'h0);
    check_val("rst_flags", {time_out, crc_error}, 2'b00);
    reset = 1'b0;
    tick();

    // CMD0, no response.
    run_cmd(40'h40_0000_0000, 2'b00, 1'b0, frame, oe_ok);
    check_val("cmd0_frame", frame, 48'h4000_0000_0095);
    check_val("cmd0_oe", oe_ok, 1'b1);
    check_val("cmd0_strobe_early", strobe_out, 1'b0);
    tick();
    check_val("cmd0_strobe", strobe_out, 1'b1);
    check_val("cmd0_oe_off", cmd_pin_oe, 1'b0);
    check_val("cmd0_resp", cmd_response, 128'h0);
    do_ack("cmd0", 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cmd_pin_oe !== 1'b0 || strobe_out !== 1'b0) seen = 1'b1;
    end
    check_val("held_strobe_ignored", seen, 1'b0);
    strobe_in = 1'b0;
    tick();

    // CMD8, short response with good CRC.
    run_cmd(40'h48_0000_01AA, 2'b01, 1'b1, frame, oe_ok);
    check_val("cmd8_frame", frame, 48'h4800_0001_AA87);
    check_val("cmd8_oe", oe_ok, 1'b1);
    tick();
    check_val("cmd8_oe_off", cmd_pin_oe, 1'b0);
    card_resp({88'h0, 48'h0800_0001_AA13}, 48, 4);
    check_val("cmd8_strobe_early", strobe_out, 1'b0);
    tick();
    check_val("cmd8_strobe", strobe_out, 1'b1);
    check_val("cmd8_resp", cmd_response, 128'h0800_0001_AA13);
    check_val("cmd8_crc", crc_error, 1'b0);
    check_val("cmd8_to", time_out, 1'b0);
    do_ack("cmd8", 1'b0);

    // CMD8 with a corrupted response CRC.
    run_cmd(40'h48_0000_01AA, 2'b11, 1'b1, frame, oe_ok);
    card_resp({88'h0, 48'h0800_0001_AA15}, 48, 5);
    tick();
    check_val("bad_strobe", strobe_out, 1'b1);
    check_val("bad_resp", cmd_response, 128'h0800_0001_AA15);
    check_val("bad_crc", crc_error, 1'b1);
    // Asynchronous reset while holding a result.
    #3;
    reset = 1'b1;
    #1;
    check_val("rst_done_strobe", strobe_out, 1'b0);
    check_val("rst_done_resp", cmd_response, 128'h0);
    check_val("rst_done_crc", crc_error, 1'b0);
    strobe_in = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // CMD2, long response.
    run_cmd(40'h42_0000_0000, 2'b10, 1'b0, frame, oe_ok);
    check_val("cmd2_frame_hi", frame[47:8], 40'h42_0000_0000);
    card_resp(long_pat, 136, 3);
    check_val("cmd2_strobe_early", strobe_out, 1'b0);
    tick();
    check_val("cmd2_strobe", strobe_out, 1'b1);
    check_val("cmd2_resp", cmd_response, long_pat[127:0]);
    check_val("cmd2_crc", crc_error, 1'b0);
    do_ack("cmd2", 1'b0);

    // CMD17, timeout enabled, card silent.
    run_cmd(40'h51_0000_0000, 2'b01, 1'b1, frame, oe_ok);
    for (int i = 0; i < 64; i++) tick();
    check_val("to_strobe_early", strobe_out, 1'b0);
    tick();
    check_val("to_strobe", strobe_out, 1'b1);
    check_val("to_flag", time_out, 1'b1);
    check_val("to_resp", cmd_response, 128'h0);
    do_ack("to", 1'b0);

    // CMD17, timeout disabled: waits indefinitely, then a late response.
    run_cmd(40'h51_0000_0000, 2'b01, 1'b0, frame, oe_ok);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (strobe_out !== 1'b0 || cmd_pin_oe !== 1'b0) seen = 1'b1;
    end
    check_val("noto_quiet", seen, 1'b0);
    card_resp({88'h0, 48'h0800_0001_AA13}, 48, 0);
    tick();
    check_val("noto_strobe", strobe_out, 1'b1);
    check_val("noto_flag", time_out, 1'b0);
    check_val("noto_resp", cmd_response, 128'h0800_0001_AA13);
    do_ack("noto", 1'b0);

    // Reset in the middle of SEND, at bit 20.
    cmd_to_send    = 40'h40_0000_0000;
    response_type  = 2'b00;
    timeout_enable = 1'b0;
    strobe_in      = 1'b1;
    tick();
    for (int i = 0; i < 21; i++) tick();
    check_val("mid_oe_on", cmd_pin_oe, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check_val("mid_rst_oe", cmd_pin_oe, 1'b0);
    check_val("mid_rst_pin", cmd_pin_out, 1'b1);
    check_val("mid_rst_hs", {strobe_out, ack_out}, 2'b00);
    strobe_in = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_val("post_rst_idle_oe", cmd_pin_oe, 1'b0);
    run_cmd(40'h40_0000_0000, 2'b00, 1'b0, frame, oe_ok);
    check_val("post_rst_frame", frame, 48'h4000_0000_0095);
    check_val("post_rst_oe", oe_ok, 1'b1);
    tick();
    check_val("post_rst_strobe", strobe_out, 1'b1);
    do_ack("post_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
